keypad_bcd_counter: RTL and testbench
=====================================

# keypad_bcd_counter

Parametrised successor to the fixed 2-digit keypad-driven BCD counter. Consumes debounced 4x4 keypad codes from the keypad scanner and runs a DIGITS-wide BCD counter with up, down, hold and clear modes. Adds keypad digit entry of the preset value, which replaces the switch preset bus, and wrap carry/borrow flags. Sits between the keypad scanner and the multiplexed 7-segment driver.

## Interface
- DIGITS, 2, number of BCD digits (1..8)
- TICK_DIV, 50_000_000, clk_50M cycles per count step (>= 2)
- clk_50M  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe: key_code holds a new key press
- key_code  in  4  key value 0x0..0xF
- bcd_out  out  4*DIGITS  display value; digit 0 in [3:0]
- carry  out  1  one-cycle pulse on up-wrap from all-9s to 0
- borrow  out  1  one-cycle pulse on down-wrap from 0 to all-9s
- mode  out  2  current state encoding: HOLD=0, UP=1, DOWN=2, ENTRY=3
- entry_active  out  1  high while in ENTRY

## Operation
- Registers:
  - count (4*DIGITS)
  - entry_buf (4*DIGITS)
  - prescaler (clog2(TICK_DIV) bits)
  - state
- Prescaler is free-running 0..TICK_DIV-1. tick=1 in the cycle it equals TICK_DIV-1, then it returns to 0. Only rst resets it.
- State transitions on key_valid:
  - 0xA: HOLD/UP/DOWN -> UP.
  - 0xB: HOLD/UP/DOWN -> DOWN.
  - 0xC: any state -> HOLD. In ENTRY this cancels entry; count is unchanged.
  - 0xD: count <= 0. State is unchanged. Ignored in ENTRY.
  - 0xE: any state -> ENTRY, entry_buf <= 0. Pressing it again in ENTRY restarts entry.
  - 0x0..0x9 in ENTRY: entry_buf <= {entry_buf[4*DIGITS-5:0], key_code}. The oldest digit drops off the top. Ignored outside ENTRY.
  - 0xF in ENTRY: count <= entry_buf, state -> HOLD. Ignored outside ENTRY.
  - 0xA/0xB in ENTRY: ignored.
- Counting occurs on tick, only in cycles with key_valid=0:
  - UP: count <= count+1 in BCD, ripple digit-wise; digit 9 -> 0 with carry into the next digit. Overflow of the top digit wraps count to 0 and sets carry=1.
  - DOWN: count <= count-1 in BCD; digit 0 -> 9 with borrow. 0 wraps to all-9s and sets borrow=1.
  - HOLD/ENTRY: no change.
- Key priority: if key_valid=1 and tick=1 in the same cycle, the tick is discarded; no count step, no carry/borrow.
- bcd_out = entry_buf while in ENTRY, otherwise count.
- Input digits are always 0..9. count never holds non-BCD nibbles.

## Timing
- All outputs are registered.
- A key or tick in cycle N is visible on bcd_out/mode/carry/borrow in cycle N+1.
- carry/borrow are high for exactly the one cycle in which the wrapped count first appears, then return to 0.
- Reset values:
  - count=0, entry_buf=0, prescaler=0
  - state=HOLD, mode=0, entry_active=0
  - bcd_out=0, carry=0, borrow=0
- rst asserted mid-entry or mid-count overrides everything in that cycle. The next cycle shows the reset values.
- Step period in UP/DOWN is exactly TICK_DIV cycles. Entering UP/DOWN does not realign the prescaler, so the first step comes after 1..TICK_DIV cycles.

## Structure
- Package keypad_bcd_pkg:
  - state encoding constants HOLD/UP/DOWN/ENTRY
  - key code constants KEY_UP=0xA, KEY_DOWN=0xB, KEY_HOLD=0xC, KEY_CLR=0xD, KEY_ENTRY=0xE, KEY_LOAD=0xF
- Sub-module bcd_updown_step: combinational, parameter DIGITS. Inputs: value, dir. Outputs: next value, wrap flag. Instantiated once.
- FSM, prescaler, entry shift register and output mux live in keypad_bcd_counter.

## Test plan
All scenarios use DIGITS=2, TICK_DIV=4.
- Reset then idle 20 cycles -> bcd_out=0x00, mode=0, carry=borrow=0 throughout.
- Key 0xA, let count run from 0x98 (loaded via entry) -> sequence 0x99 then 0x00 with carry=1 for one cycle. Steps occur every 4 cycles.
- Key 0xB from 0x00 -> 0x99 with borrow=1 for one cycle, then 0x98 four cycles later.
- Keys E,1,2,3,F -> bcd_out shows 0x01, 0x12, 0x23 during entry; after F, count=0x23, mode=0, entry_active=0.
- In UP, key 0xA strobed in the same cycle as tick -> count unchanged that cycle, no carry; the next step occurs 4 cycles later.
- During ENTRY press 7 then C -> bcd_out returns to the prior count. Then assert rst in mid-UP -> next cycle all reset values.

Source files
------------

// File: rtl/keypad_bcd_pkg.sv
// Shared encodings for the keypad-driven BCD counter: FSM states and keypad command codes.
package keypad_bcd_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        UP    = 2'd1,
        DOWN  = 2'd2,
        ENTRY = 2'd3
    } state_t;

    localparam logic [3:0] KEY_UP    = 4'hA;
    localparam logic [3:0] KEY_DOWN  = 4'hB;
    localparam logic [3:0] KEY_HOLD  = 4'hC;
    localparam logic [3:0] KEY_CLR   = 4'hD;
    localparam logic [3:0] KEY_ENTRY = 4'hE;
    localparam logic [3:0] KEY_LOAD  = 4'hF;

endpackage

// File: rtl/bcd_updown_step.sv
// Combinational +/-1 on a multi-digit BCD value with digit-wise ripple.
// wrap is set when the ripple leaves the top digit (all-9s -> 0 up, 0 -> all-9s down).
module bcd_updown_step #(
    parameter int DIGITS = 2
) (
    input  logic [4*DIGITS-1:0] value,
    input  logic                dir,        // 0 = count up, 1 = count down
    output logic [4*DIGITS-1:0] next_value,
    output logic                wrap
);

    logic       ripple;
    logic [3:0] digit;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        next_value = value;
        ripple     = 1'b1;
        digit      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = value[4*i +: 4];
            if (ripple) begin
                if (!dir) begin
                    if (digit == 4'd9) begin
                        next_value[4*i +: 4] = 4'd0;
                    end else begin
                        next_value[4*i +: 4] = digit + 4'd1;
                        ripple               = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        next_value[4*i +: 4] = 4'd9;
                    end else begin
                        next_value[4*i +: 4] = digit - 4'd1;
                        ripple               = 1'b0;
                    end
                end
            end
        end
        wrap = ripple;
    end

endmodule

// File: rtl/keypad_bcd_counter.sv
// Keypad-controlled DIGITS-wide BCD up/down counter with keypad preset entry.
// All outputs come straight from flops; the next-output values are decoded from the next state.
module keypad_bcd_counter
    import keypad_bcd_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                clk_50M,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                carry,
    output logic                borrow,
    output logic [1:0]          mode,
    output logic                entry_active
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_t         state, state_next;
    logic [W-1:0]   count, count_next;
    logic [W-1:0]   entry_buf, entry_next;
    logic [W-1:0]   step_value;
    logic [W-1:0]   bcd_next;
    logic [PW-1:0]  prescaler;
    logic           tick, step_wrap;
    logic           carry_next, borrow_next, entry_active_next;

    assign tick = (prescaler == PRE_LAST);

    // Free-running: mode changes never realign the step phase.
    // NOTE: sequential state is written with <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    bcd_updown_step #(.DIGITS(DIGITS)) u_step (
        .value      (count),
        .dir        (state == DOWN),
        .next_value (step_value),
        .wrap       (step_wrap)
    );

    // State and datapath registers.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state        <= HOLD;
            count        <= '0;
            entry_buf    <= '0;
            bcd_out      <= '0;
            carry        <= 1'b0;
            borrow       <= 1'b0;
            entry_active <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            entry_buf    <= entry_next;
            bcd_out      <= bcd_next;
            carry        <= carry_next;
            borrow       <= borrow_next;
            entry_active <= entry_active_next;
        end
    end

    // Next-state: a key press always wins over a coincident tick.
    always_comb begin
        state_next  = state;
        count_next  = count;
        entry_next  = entry_buf;
        carry_next  = 1'b0;
        borrow_next = 1'b0;
        if (key_valid) begin
            case (key_code)
                KEY_UP:    if (state != ENTRY) state_next = UP;
                KEY_DOWN:  if (state != ENTRY) state_next = DOWN;
                KEY_HOLD:  state_next = HOLD;
                KEY_CLR:   if (state != ENTRY) count_next = '0;
                KEY_ENTRY: begin
                    state_next = ENTRY;
                    entry_next = '0;
                end
                KEY_LOAD: begin
                    if (state == ENTRY) begin
                        count_next = entry_buf;
                        state_next = HOLD;
                    end
                end
                default: begin
                    // Decimal digit: shift in at the bottom, oldest digit falls off the top.
                    if (state == ENTRY) entry_next = (entry_buf << 4) | W'(key_code);
                end
            endcase
        end else if (tick && (state == UP || state == DOWN)) begin
            count_next  = step_value;
            carry_next  = (state == UP)   && step_wrap;
            borrow_next = (state == DOWN) && step_wrap;
        end
    end

    // Output decode from the next state so the outputs themselves are registered.
    always_comb begin
        entry_active_next = (state_next == ENTRY);
        bcd_next          = entry_active_next ? entry_next : count_next;
    end

    assign mode = state;

endmodule

// File: tb/tb_keypad_bcd_counter.sv
// Self-checking bench for keypad_bcd_counter (DIGITS=2, TICK_DIV=4): directed table,
// multi-cycle corner sequences and random keys against an integer-arithmetic reference model.
module tb_keypad_bcd_counter;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
    localparam int MAXV     = 99;

    logic       clk_50M = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [7:0] bcd_out;
    logic       carry, borrow, entry_active;
    logic [1:0] mode;

    int checks   = 0;
    int failures = 0;

    // Reference model: decimal integers, mode numbers, cycle counter for the step phase.
    int m_count, m_entry, m_state, m_pre;
    bit m_carry, m_borrow;

    keypad_bcd_counter #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
        .clk_50M      (clk_50M),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .bcd_out      (bcd_out),
        .carry        (carry),
        .borrow       (borrow),
        .mode         (mode),
        .entry_active (entry_active)
    );

    always #5 clk_50M = ~clk_50M;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit kv, input logic [3:0] kc, input bit r);
        bit tick;
        tick = (m_pre == TICK_DIV - 1);
        m_pre = (m_pre + 1) % TICK_DIV;
        m_carry  = 0;
        m_borrow = 0;
        if (r) begin
            m_count = 0; m_entry = 0; m_state = 0; m_pre = 0;
        end else if (kv) begin
            case (kc)
                4'hA: if (m_state != 3) m_state = 1;
                4'hB: if (m_state != 3) m_state = 2;
                4'hC: m_state = 0;
                4'hD: if (m_state != 3) m_count = 0;
                4'hE: begin m_state = 3; m_entry = 0; end
                4'hF: if (m_state == 3) begin m_count = m_entry; m_state = 0; end
                default: if (m_state == 3) m_entry = (m_entry * 10 + int'(kc)) % (MAXV + 1);
            endcase
        end else if (tick) begin
            if (m_state == 1) begin
                if (m_count == MAXV) begin m_count = 0; m_carry = 1; end
                else m_count++;
            end else if (m_state == 2) begin
                if (m_count == 0) begin m_count = MAXV; m_borrow = 1; end
                else m_count--;
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare just after it.
    task automatic do_cycle(input bit kv, input logic [3:0] kc, input bit r);
        key_valid = kv;
        key_code  = kc;
        rst       = r;
        @(posedge clk_50M);
        model_step(kv, kc, r);
        #1;
        key_valid = 1'b0;
        rst       = 1'b0;
        check("bcd_out", bcd_out, to_bcd(m_state == 3 ? m_entry : m_count));
        check("mode", mode, m_state);
        check("entry_active", entry_active, m_state == 3);
        check("carry", carry, m_carry);
        check("borrow", borrow, m_borrow);
    endtask

    task automatic press(input logic [3:0] kc);
        do_cycle(1'b1, kc, 1'b0);
    endtask

    task automatic run_until(input string name, input logic [7:0] target, input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            do_cycle(1'b0, 4'h0, 1'b0);
            if (bcd_out == target) begin
                n = k;
                break;
            end
        end
        check(name, n != -1, 1);
    endtask

    typedef struct packed {
        logic       kv;
        logic [3:0] kc;
        logic       r;
        logic [7:0] bcd;
        logic [1:0] md;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int n, n2;
        logic [7:0] held;

        vecs[0]  = '{1'b0, 4'h0, 1'b1, 8'h00, 2'd0};
        vecs[1]  = '{1'b1, 4'hE, 1'b0, 8'h00, 2'd3};
        vecs[2]  = '{1'b1, 4'h1, 1'b0, 8'h01, 2'd3};
        vecs[3]  = '{1'b1, 4'h2, 1'b0, 8'h12, 2'd3};
        vecs[4]  = '{1'b1, 4'h3, 1'b0, 8'h23, 2'd3};
        vecs[5]  = '{1'b1, 4'hF, 1'b0, 8'h23, 2'd0};
        vecs[6]  = '{1'b0, 4'h0, 1'b0, 8'h23, 2'd0};
        vecs[7]  = '{1'b1, 4'hE, 1'b0, 8'h00, 2'd3};
        vecs[8]  = '{1'b1, 4'h7, 1'b0, 8'h07, 2'd3};
        vecs[9]  = '{1'b1, 4'hC, 1'b0, 8'h23, 2'd0};
        vecs[10] = '{1'b1, 4'hE, 1'b0, 8'h00, 2'd3};
        vecs[11] = '{1'b1, 4'hA, 1'b0, 8'h00, 2'd3};
        vecs[12] = '{1'b1, 4'h5, 1'b0, 8'h05, 2'd3};
        vecs[13] = '{1'b1, 4'hD, 1'b0, 8'h05, 2'd3};
        vecs[14] = '{1'b1, 4'hF, 1'b0, 8'h05, 2'd0};
        vecs[15] = '{1'b1, 4'hD, 1'b0, 8'h00, 2'd0};

        m_count = 0; m_entry = 0; m_state = 0; m_pre = 0;
        m_carry = 0; m_borrow = 0;

        // Directed table: entry, cancel, ignored keys, load, clear.
        for (int i = 0; i < 16; i++) begin
            do_cycle(vecs[i].kv, vecs[i].kc, vecs[i].r);
            check($sformatf("vec%0d_bcd", i), bcd_out, vecs[i].bcd);
            check($sformatf("vec%0d_mode", i), mode, vecs[i].md);
            check($sformatf("vec%0d_entry_active", i), entry_active, vecs[i].md == 2'd3);
        end

        // Reset then 20 idle cycles: nothing moves.
        do_cycle(1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b0, 4'h0, 1'b0);
            check("idle_bcd", bcd_out, 8'h00);
            check("idle_flags", {carry, borrow, mode}, 4'b0000);
        end

        // Up-wrap from 98: 99, then 00 with a single-cycle carry, steps 4 cycles apart.
        press(4'hE); press(4'h9); press(4'h8); press(4'hF);
        press(4'hA);
        check("up_start", bcd_out, 8'h98);
        run_until("reach_99", 8'h99, 2 * TICK_DIV, n);
        run_until("reach_00", 8'h00, 2 * TICK_DIV, n2);
        check("up_period", n2, TICK_DIV);
        check("carry_on_wrap", carry, 1'b1);
        do_cycle(1'b0, 4'h0, 1'b0);
        check("carry_one_cycle", carry, 1'b0);

        // Down-wrap from 00: 99 with a single-cycle borrow, then 98 one period later.
        press(4'hC); press(4'hD); press(4'hB);
        check("down_start", bcd_out, 8'h00);
        run_until("reach_99_down", 8'h99, 2 * TICK_DIV, n);
        check("borrow_on_wrap", borrow, 1'b1);
        run_until("reach_98_down", 8'h98, 2 * TICK_DIV, n2);
        check("down_period", n2, TICK_DIV);
        check("borrow_cleared", borrow, 1'b0);

        // Key strobed in a tick cycle suppresses that step; next step one full period later.
        press(4'hA);
        for (int k = 0; k < TICK_DIV && m_pre != TICK_DIV - 1; k++) do_cycle(1'b0, 4'h0, 1'b0);
        check("aligned_to_tick", m_pre, TICK_DIV - 1);
        held = bcd_out;
        press(4'hA);
        check("collide_no_step", bcd_out, held);
        check("collide_no_carry", carry, 1'b0);
        run_until("collide_next_step", to_bcd((m_count + 1) % (MAXV + 1)), 2 * TICK_DIV, n);
        check("collide_period", n, TICK_DIV);

        // Entry cancel restores the running count; then reset mid-UP.
        press(4'hE); press(4'h7);
        check("entry_shows_7", bcd_out, 8'h07);
        held = to_bcd(m_count);
        press(4'hC);
        check("cancel_restores", bcd_out, held);
        press(4'hA);
        do_cycle(1'b0, 4'h0, 1'b0);
        do_cycle(1'b0, 4'h0, 1'b0);
        do_cycle(1'b1, 4'hE, 1'b1);
        check("rst_bcd", bcd_out, 8'h00);
        check("rst_mode", mode, 2'd0);
        check("rst_flags", {carry, borrow, entry_active}, 3'b000);

        // Random keys and occasional resets against the model.
        for (int i = 0; i < 500; i++) begin
            do_cycle($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
